// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Multi-channel push-button front end. Each channel:
//   raw button -> 2-flop synchroniser -> polarity normalisation (s, 1 = pressed)
//   -> debounce counter (o_Deb) -> RELEASED/PRESSED/LONG FSM that emits
//   press/release/long-press pulses and captures the held time.
// Channels are fully independent; there is no shared state between them.
//
// Parameters
//   N_CH        number of button channels
//   DEB_CYCLES  consecutive differing synchronised samples needed to flip o_Deb (>= 1)
//   CNT_W       width of each held-time counter
//   ACTIVE_LOW  1: raw 0 means pressed, 0: raw 1 means pressed
//   LONG_PRESS  held cycles at which o_Long fires (0 or > 2^CNT_W-1 disables it)
//
// Ports
//   clk           single clock, everything on its rising edge
//   i_Reset       synchronous active-high reset
//   i_Btn         raw asynchronous button levels, one bit per channel
//   o_Deb         debounced level, 1 = pressed
//   o_PE          one-cycle pulse in the first cycle o_Deb is 1
//   o_NE          one-cycle pulse in the first cycle o_Deb is 0 after a press
//   o_Long        one-cycle pulse when a press reaches LONG_PRESS cycles
//   o_Count       last captured held time, channel c at [c*CNT_W +: CNT_W]
//   o_CountValid  one-cycle pulse when that channel's o_Count updates
//   o_State       per-channel FSM state, channel c at [2*c +: 2]
//                 (0 = RELEASED, 1 = PRESSED, 2 = LONG), for observation
//
// Handshake: the pulse outputs are plain strobes with no ready/backpressure;
// a consumer must sample them in the cycle they are high. o_Count is stable
// whenever o_CountValid is high and stays stable until the next release on
// the same channel.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_CH       = 3,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 12,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_PRESS = 2000
) (
    input  logic                    clk,
    input  logic                    i_Reset,
    input  logic [N_CH-1:0]         i_Btn,
    output logic [N_CH-1:0]         o_Deb,
    output logic [N_CH-1:0]         o_PE,
    output logic [N_CH-1:0]         o_NE,
    output logic [N_CH-1:0]         o_Long,
    output logic [N_CH*CNT_W-1:0]   o_Count,
    output logic [N_CH-1:0]         o_CountValid,
    output logic [2*N_CH-1:0]       o_State
);

    localparam int STAB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEB_CYCLES - 1);

    // Raw level that means "released"; synchroniser flops reset to this so a
    // button held through reset is seen as a fresh press afterwards.
    localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Long-press detection only exists when the threshold is reachable by a
    // saturating CNT_W-bit counter and is non-zero.
    localparam logic [63:0] MAX_RUN  = (64'd1 << CNT_W) - 64'd1;
    localparam logic [63:0] LONG_U   = 64'(LONG_PRESS);
    localparam bit          LONG_EN  = (LONG_PRESS > 0) && (LONG_U <= MAX_RUN);
    localparam logic [CNT_W-1:0] LONG_VAL = CNT_W'(LONG_PRESS);
    localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_LONG     = 2'd2
    } state_t;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch

        logic              sync1;
        logic              sync2;
        logic              s;
        logic [STAB_W-1:0] stab;
        logic [STAB_W-1:0] stab_next;
        logic              deb;
        logic              deb_next;
        state_t            state;
        state_t            state_next;
        logic [CNT_W-1:0]  run;
        logic [CNT_W-1:0]  run_next;
        logic [CNT_W-1:0]  run_inc;
        logic [CNT_W-1:0]  count;
        logic [CNT_W-1:0]  count_next;
        logic              pe;
        logic              pe_next;
        logic              ne;
        logic              ne_next;
        logic              lng;
        logic              lng_next;
        logic              cv;
        logic              cv_next;

        // Normalised synchronised sample, 1 = pressed.
        assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

        // Saturating increment: run sticks at all-ones instead of wrapping.
        assign run_inc = (run == RUN_MAX) ? run : run + RUN_ONE;

        // State register: synchroniser, debounce, FSM and registered outputs.
        always_ff @(posedge clk) begin
            if (i_Reset) begin
                sync1 <= REL_LVL;
                sync2 <= REL_LVL;
                stab  <= '0;
                deb   <= 1'b0;
                state <= ST_RELEASED;
                run   <= '0;
                count <= '0;
                pe    <= 1'b0;
                ne    <= 1'b0;
                lng   <= 1'b0;
                cv    <= 1'b0;
            end else begin
                sync1 <= i_Btn[c];
                sync2 <= sync1;
                stab  <= stab_next;
                deb   <= deb_next;
                state <= state_next;
                run   <= run_next;
                count <= count_next;
                pe    <= pe_next;
                ne    <= ne_next;
                lng   <= lng_next;
                cv    <= cv_next;
            end
        end

        // Debounce: stab counts consecutive samples that disagree with deb;
        // the DEB_CYCLES-th disagreeing sample flips deb. Any agreeing sample
        // clears the run, so short glitches never reach deb.
        always_comb begin
            stab_next = '0;
            deb_next  = deb;
            if (s != deb) begin
                if (stab == STAB_LAST) begin
                    deb_next  = ~deb;
                    stab_next = '0;
                end else begin
                    stab_next = stab + STAB_W'(1);
                end
            end
        end

        // FSM next state and next registered outputs. Decisions are taken on
        // deb_next so the pulses land in the same cycle o_Deb changes.
        always_comb begin
            state_next = state;
            run_next   = run;
            count_next = count;
            pe_next    = 1'b0;
            ne_next    = 1'b0;
            lng_next   = 1'b0;
            cv_next    = 1'b0;

            case (state)
                ST_RELEASED: begin
                    if (deb_next && !deb) begin
                        state_next = ST_PRESSED;
                        run_next   = RUN_ONE;
                        pe_next    = 1'b1;
                        // A threshold of one is reached on the press cycle itself.
                        if (LONG_EN && (LONG_VAL == RUN_ONE)) begin
                            state_next = ST_LONG;
                            lng_next   = 1'b1;
                        end
                    end
                end

                ST_PRESSED: begin
                    if (deb && !deb_next) begin
                        state_next = ST_RELEASED;
                        count_next = run;
                        run_next   = '0;
                        ne_next    = 1'b1;
                        cv_next    = 1'b1;
                    end else begin
                        run_next = run_inc;
                        if (LONG_EN && (run_inc == LONG_VAL)) begin
                            state_next = ST_LONG;
                            lng_next   = 1'b1;
                        end
                    end
                end

                ST_LONG: begin
                    if (deb && !deb_next) begin
                        state_next = ST_RELEASED;
                        count_next = run;
                        run_next   = '0;
                        ne_next    = 1'b1;
                        cv_next    = 1'b1;
                    end else begin
                        run_next = run_inc;
                    end
                end

                default: begin
                    state_next = ST_RELEASED;
                    run_next   = '0;
                end
            endcase
        end

        assign o_Deb[c]                   = deb;
        assign o_PE[c]                    = pe;
        assign o_NE[c]                    = ne;
        assign o_Long[c]                  = lng;
        assign o_CountValid[c]            = cv;
        assign o_Count[c*CNT_W +: CNT_W]  = count;
        assign o_State[2*c +: 2]          = state;

    end : g_ch

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner at default parameters. Stimulus is
// applied on the falling clock edge; every expected pulse event (cycle number,
// PE/NE/Long/CountValid vectors and the full o_Count bus) is pushed into a
// queue when the stimulus is issued. A monitor on the falling edge pops and
// compares whenever any pulse output is high. A raw input change applied at
// the falling edge after rising edge k produces o_Deb/o_PE at rising edge k+6;
// a press applied after edge k and released after edge k2 captures k2-k.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N_CH  = 3;
  localparam int CNT_W = 12;
  localparam int W     = 32 + 4 * N_CH + N_CH * CNT_W;

  logic                  clk;
  logic                  i_Reset;
  logic [N_CH-1:0]       i_Btn;
  logic [N_CH-1:0]       o_Deb;
  logic [N_CH-1:0]       o_PE;
  logic [N_CH-1:0]       o_NE;
  logic [N_CH-1:0]       o_Long;
  logic [N_CH*CNT_W-1:0] o_Count;
  logic [N_CH-1:0]       o_CountValid;
  logic [2*N_CH-1:0]     o_State;

  button_conditioner dut (
    .clk          (clk),
    .i_Reset      (i_Reset),
    .i_Btn        (i_Btn),
    .o_Deb        (o_Deb),
    .o_PE         (o_PE),
    .o_NE         (o_NE),
    .o_Long       (o_Long),
    .o_Count      (o_Count),
    .o_CountValid (o_CountValid),
    .o_State      (o_State)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_cnt[N_CH];
  int               checks = 0;
  int               errors = 0;
  int               deb0_hi = 0;

  always @(negedge clk) begin
    if (o_Deb[0] === 1'b1) deb0_hi++;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if ((|o_PE) || (|o_NE) || (|o_Long) || (|o_CountValid)) begin
      got = {32'(cyc), o_PE, o_NE, o_Long, o_CountValid, o_Count};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d pe=%b ne=%b long=%b cv=%b count=%h",
                 cyc, o_PE, o_NE, o_Long, o_CountValid, o_Count);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL event got cyc=%0d pe=%b ne=%b long=%b cv=%b count=%h | exp cyc=%0d pe=%b ne=%b long=%b cv=%b count=%h",
                   got[W-1 -: 32], got[47:45], got[44:42], got[41:39], got[38:36], got[35:0],
                   exp[W-1 -: 32], exp[47:45], exp[44:42], exp[41:39], exp[38:36], exp[35:0]);
        end
      end
    end
  end

  // ---------------- driver / helper tasks ----------------
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_ev(input int at, input logic [2:0] pe, input logic [2:0] ne,
                         input logic [2:0] lg, input logic [2:0] cv);
    exp_q.push_back({32'(at), pe, ne, lg, cv, exp_cnt[2], exp_cnt[1], exp_cnt[0]});
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_pulses"}, 64'({o_Deb, o_PE, o_NE, o_Long, o_CountValid}), 64'd0);
    check({name, "_count"}, 64'(o_Count), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N_CH; i++) exp_cnt[i] = '0;
    i_Reset = 1'b1;
    i_Btn   = 3'b000;

    // 1. Reset with all buttons held; outputs quiet during reset.
    wait_until(1); check_quiet("reset_c1");
    wait_until(2); check_quiet("reset_c2");
    wait_until(3); check_quiet("reset_c3");
    i_Reset = 1'b0;                       // after edge 3
    push_ev(9, 3'b111, 3'b000, 3'b000, 3'b000);
    wait_until(12);
    i_Btn = 3'b111;                       // release all, held 9 cycles
    for (int i = 0; i < N_CH; i++) exp_cnt[i] = 12'd9;
    push_ev(18, 3'b000, 3'b111, 3'b000, 3'b111);

    // 2. Clean 20-cycle press on ch0.
    wait_until(25);
    deb0_hi = 0;
    i_Btn[0] = 1'b0;
    push_ev(31, 3'b001, 3'b000, 3'b000, 3'b000);
    wait_until(45);
    i_Btn[0] = 1'b1;
    exp_cnt[0] = 12'd20;
    push_ev(51, 3'b000, 3'b001, 3'b000, 3'b001);
    wait_until(55);
    check("deb0_high_cycles", 64'(deb0_hi), 64'd20);
    check("count0_clean", 64'(o_Count[11:0]), 64'd20);

    // 3. Bounce on ch1: 2-cycle toggles, then settle low; then 3-cycle glitch.
    for (int i = 0; i < 6; i++) begin
      wait_until(60 + 2 * i);
      i_Btn[1] = i[0];                    // low, high, low, ...
    end
    wait_until(72);
    i_Btn[1] = 1'b0;
    push_ev(78, 3'b010, 3'b000, 3'b000, 3'b000);
    wait_until(90);
    i_Btn[1] = 1'b1;                      // 3-cycle release glitch
    wait_until(93);
    i_Btn[1] = 1'b0;
    wait_until(100);
    check("deb1_after_glitch", 64'(o_Deb[1]), 64'd1);
    wait_until(110);
    i_Btn[1] = 1'b1;
    exp_cnt[1] = 12'd38;
    push_ev(116, 3'b000, 3'b010, 3'b000, 3'b010);

    // 4. Long press on ch2: 2500 debounced cycles.
    wait_until(130);
    i_Btn[2] = 1'b0;
    push_ev(136,  3'b100, 3'b000, 3'b000, 3'b000);
    push_ev(2135, 3'b000, 3'b000, 3'b100, 3'b000);
    wait_until(2630);
    i_Btn[2] = 1'b1;
    exp_cnt[2] = 12'd2500;
    push_ev(2636, 3'b000, 3'b100, 3'b000, 3'b100);

    // 5. Saturation on ch0: 5000 debounced cycles.
    wait_until(2650);
    i_Btn[0] = 1'b0;
    push_ev(2656, 3'b001, 3'b000, 3'b000, 3'b000);
    push_ev(4655, 3'b000, 3'b000, 3'b001, 3'b000);
    wait_until(7650);
    i_Btn[0] = 1'b1;
    exp_cnt[0] = 12'd4095;
    push_ev(7656, 3'b000, 3'b001, 3'b000, 3'b001);
    wait_until(7660);
    check("count0_saturated", 64'(o_Count[11:0]), 64'd4095);

    // 6. Simultaneous press on ch1/ch2, reset mid-press, press survives reset.
    wait_until(7670);
    i_Btn = 3'b001;
    push_ev(7676, 3'b110, 3'b000, 3'b000, 3'b000);
    wait_until(7690);
    i_Reset = 1'b1;
    for (int i = 0; i < N_CH; i++) exp_cnt[i] = '0;
    wait_until(7691); check_quiet("midpress_reset_c1");
    wait_until(7692); check_quiet("midpress_reset_c2");
    i_Reset = 1'b0;                       // buttons still held
    push_ev(7698, 3'b110, 3'b000, 3'b000, 3'b000);
    wait_until(7697);
    check("count_after_reset", 64'(o_Count), 64'd0);
    wait_until(7710);
    i_Btn = 3'b111;
    exp_cnt[1] = 12'd18;
    exp_cnt[2] = 12'd18;
    push_ev(7716, 3'b000, 3'b110, 3'b000, 3'b110);
    wait_until(7730);

    // Every expected event must have been consumed.
    check("events_left", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_button_conditioner

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel front end for the board push-buttons (Hit, Stay, Reset and future inputs). Each channel synchronises a raw active-low button to `clk` and debounces it. It then produces a level output, press and release edge pulses, and a long-press pulse, and measures how long the button was held. The held-time count feeds the shuffler seed path and the game controller. Each channel is fully independent; channel count, debounce depth and counter width are parameters.

## Interface
- `N_CH`, default 3: number of button channels.
- `DEB_CYCLES`, default 4: consecutive identical synchronised samples needed to change state. Must be ≥1.
- `CNT_W`, default 12: width of each held-time counter.
- `ACTIVE_LOW`, default 1: 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".
- `LONG_PRESS`, default 2000: held cycles at which `o_Long` fires.

- `clk` input, 1: single clock, all logic on its rising edge.
- `i_Reset` input, 1: synchronous, active-high reset.
- `i_Btn` input, N_CH: raw asynchronous button levels.
- `o_Deb` output, N_CH: debounced level, 1 = pressed.
- `o_PE` output, N_CH: one-cycle pulse on the press edge.
- `o_NE` output, N_CH: one-cycle pulse on the release edge.
- `o_Long` output, N_CH: one-cycle pulse when a press reaches LONG_PRESS cycles.
- `o_Count` output, N_CH*CNT_W: last captured held time. Channel c occupies bits [c*CNT_W +: CNT_W].
- `o_CountValid` output, N_CH: one-cycle pulse when `o_Count` for that channel updates.

## Operation
- **Synchroniser.** Per channel, two flops followed by polarity normalisation give the sample `s` (1 = pressed).
- **Debounce counter.**
  - Per channel: `stab`, width clog2(DEB_CYCLES+1).
  - If `s` differs from `o_Deb`, `stab` increments.
  - If `s` equals `o_Deb`, `stab` clears to 0.
  - When `s` differs and `stab` equals DEB_CYCLES-1, `o_Deb` toggles and `stab` clears.
- **Per-channel FSM.**
  - States: RELEASED, PRESSED, LONG.
  - RELEASED→PRESSED: `o_Deb` rises. In that same cycle `o_PE`=1 and `run` is loaded with 1.
  - PRESSED: `run` increments by 1 each cycle. It saturates at 2^CNT_W-1 and never wraps.
  - PRESSED→LONG: on the cycle `run` becomes LONG_PRESS. In that cycle `o_Long`=1, exactly once per press.
    - If LONG_PRESS > 2^CNT_W-1, or LONG_PRESS = 0, LONG is never entered.
    - If LONG_PRESS = 1, `o_Long` coincides with `o_PE`.
  - LONG: `run` keeps counting and saturating.
  - PRESSED or LONG → RELEASED: `o_Deb` falls. In that cycle `o_NE`=1 and `o_CountValid`=1, and `o_Count` holds the final `run`. That value is the number of cycles `o_Deb` was 1, saturated.
- **Holding `o_Count`.** The value is held until that channel's next release.
- **Independence.** Channels never interact. Simultaneous events on several channels all produce pulses in the same cycle.
- **Reset.**
  - Reset dominates everything and is applied regardless of `i_Btn`.
  - Synchroniser flops are loaded with the released level.
  - `stab`, `run` and `o_Count` go to 0; `o_Deb`, `o_PE`, `o_NE`, `o_Long` and `o_CountValid` go to 0; FSM goes to RELEASED.
  - Reset mid-press discards the press: no `o_NE`, no count capture.
  - A button still held after reset is seen as a new press.

## Timing
- Define edge 1 as the first edge where the raw input change meets setup.
  - `s` changes at edge 2.
  - `o_Deb` changes at edge 2+DEB_CYCLES, provided the input stays stable.
  - Latency is DEB_CYCLES+2 cycles; with the default, 6.
- Pulse alignment, all outputs registered:
  - `o_PE` is high in the first cycle `o_Deb`=1.
  - `o_NE` and `o_CountValid` are high in the first cycle `o_Deb`=0.
  - `o_Count` updates on the same edge that raises `o_CountValid`.
- Any `s` glitch shorter than DEB_CYCLES samples produces no output change.
- The minimum press pulse width is DEB_CYCLES cycles; so is the minimum release.
- The first press after reset deassertion is reported no earlier than DEB_CYCLES+2 cycles later.

## Test plan
All scenarios use default parameters.
1. **Reset.** Drive `i_Btn`=3'b000 (all pressed) and `i_Reset`=1 for 3 cycles. Every output must be 0 during reset. After release, `o_PE`=3'b111 appears exactly 6 cycles later.
2. **Clean press, ch0.** Drive `i_Btn[0]` 1→0 and hold 20 cycles, then 1. Required:
   - `o_PE[0]` pulses 6 edges after the fall.
   - `o_Deb[0]` is high for exactly 20 cycles.
   - `o_NE[0]` and `o_CountValid[0]` pulse together.
   - `o_Count[11:0]`=20.
   - `o_Long[0]` never fires.
3. **Bounce.** Toggle `i_Btn[1]` every 2 cycles for 12 cycles, then hold low. Required: no pulses during the bounce, then a single `o_PE[1]` 6 edges after the final settle. A 3-cycle high glitch while pressed produces no `o_NE`.
4. **Long press.** Hold `i_Btn[2]` low for 2500 debounced cycles. Required: one `o_Long[2]` pulse on the 2000th cycle of `o_Deb[2]`=1, and `o_Count[35:24]`=2500 on release.
5. **Saturation.** Hold ch0 for 5000 debounced cycles. Required: `o_Count[11:0]`=4095, exactly one `o_Long[0]`, and the counter does not wrap.
6. **Simultaneous events and reset mid-press.**
   - Press ch1 and ch2 in the same cycle: both `o_PE` bits pulse in the same cycle.
   - Assert `i_Reset` while both are held: no `o_NE` or `o_CountValid`, and `o_Count` is 0.
   - Deassert reset while the buttons are still held: fresh `o_PE` 6 cycles later.
